ifu: RTL
========

# ifu

Instruction fetch unit: owns the program counter, drives the word address into the instruction memory, and presents fetched instructions to the decode stage through a one-entry valid/ready output register. It is the initiator on the instruction-memory read interface. The memory is a combinational 1024-word array mapped at byte address 0x0000_3000. The block also computes branch, jump and jump-register targets on redirect requests from decode, and flags fetches that fall outside the memory window.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset; also the instruction-memory base address.
- IM_WORDS, 1024, instruction-memory depth in words; valid window is [RESET_PC, RESET_PC + 4*IM_WORDS).
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- imem_addr  output  32  byte address to instruction memory; always equal to the PC register.
- imem_instr  input  32  instruction word returned combinationally for imem_addr.
- id_valid  output  1  output register holds a valid instruction.
- id_ready  input  1  decode accepts the output register this cycle.
- id_instr  output  32  fetched instruction.
- id_pc  output  32  byte address of id_instr.
- redir_op  input  2  00 none, 01 branch, 10 jump (j/jal), 11 register (jr).
- redir_pc  input  32  PC of the redirecting instruction.
- redir_imm  input  26  branch uses [15:0]; jump uses [25:0].
- redir_reg  input  32  jr target.
- fault  output  1  sticky fetch-address error.

## Operation
- Reset: pc = RESET_PC, id_valid = 0, id_instr = 0, id_pc = 0, fault = 0.
- Address check on the current pc: it is bad if pc[1:0] != 0, or pc < RESET_PC, or pc - RESET_PC >= 4*IM_WORDS (unsigned).
- Per-cycle priority, highest first:
  1. reset.
  2. redir_op != 00: pc <= target; id_valid <= 0 (flush, even if id_ready = 0); the output register data is don't-care.
  3. fault = 1: pc and the output register hold. id_valid is cleared by a handshake and never reloaded.
  4. Bad address: fault <= 1; no load; pc holds.
  5. Load: if id_valid = 0 or id_ready = 1, then id_instr <= imem_instr, id_pc <= pc, id_valid <= 1, pc <= pc + 4.
  6. Otherwise (stall): everything holds.
- fault stays set until reset; a redirect does not clear it.
- Target arithmetic is 32-bit wraparound. Let seq = redir_pc + 4.
  - Branch: seq + (sign-extended redir_imm[15:0] << 2).
  - Jump: {seq[31:28], redir_imm[25:0], 2'b00}.
  - Register: redir_reg unmodified. Misalignment is caught as a fault on the following cycle.
- No delay slot. The link value (id_pc + 4) is computed by decode, not by this block.
- redir_* inputs are ignored when redir_op = 00.

## Timing
- imem_addr follows pc with zero latency; the instruction is captured the same cycle.
- First valid instruction: id_valid = 1 with id_pc = RESET_PC one cycle after the reset cycle.
- Steady state with id_ready held at 1: one instruction per cycle, and id_pc increments by 4 each cycle.
- Redirect asserted in cycle N:
  - id_valid = 0 in N+1, with pc = target.
  - Target instruction is presented in N+2.
  - Branch penalty is one bubble.
- Back-to-back redirects: the latest one wins and each flushes.
- Stall: id_instr and id_pc stay stable while id_valid = 1 and id_ready = 0.
- A bad address detected in cycle N sets fault in N+1. An already-valid output entry may still complete its handshake.
- Reset mid-stream: the state reaches reset values at the next edge regardless of redirect or stall.

## Structure
- Package ifu_pkg holds:
  - redir_op encodings REDIR_NONE, REDIR_BR, REDIR_J, REDIR_JR;
  - IM_BASE = 32'h0000_3000;
  - IM_WORDS_DEFAULT = 1024.
- Sub-module npc: combinational target calculator with inputs redir_op, redir_pc, redir_imm, redir_reg and output target. It is reused by the single-cycle datapath.
- The top level contains the PC register, the address-window check, the output register and the fault flag.

## Test plan
- Reset, then id_ready = 1 for 4 cycles: id_pc = 0x3000, 0x3004, 0x3008, 0x300C on consecutive cycles, with id_instr equal to memory words 0..3.
- Hold id_ready = 0 for 3 cycles after the first load: id_pc stays 0x3000, imem_addr stays 0x3004. Release: 0x3004 is presented next cycle.
- Branch with redir_pc = 0x3010 and imm = 0xFFFD: the target is 0x3008, one bubble, then id_pc = 0x3008.
- Jump with redir_pc = 0x3020 and imm26 = 0x0000C10: the target is 0x3040. Then jr with redir_reg = 0x3001: fault rises the next cycle, id_valid stays 0, and pc holds at 0x3001.
- Sequential fetch to 0x3FFC, then pc = 0x4000: fault = 1, and no instruction from 0x4000 is ever presented.
- Redirect and stall together (id_valid = 1, id_ready = 0, redir_op = 01): the flush wins and id_valid = 0 next cycle. Then reset is asserted during a redirect: pc = 0x3000 and fault = 0 at the next edge.

Source files
------------

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared encodings and constants for the instruction fetch unit
package ifu_pkg;

  // Redirect request kinds issued by decode
  typedef enum logic [1:0] {
    REDIR_NONE = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_JR   = 2'b11
  } redir_op_e;

  // Instruction memory base byte address and depth in words
  localparam logic [31:0] IM_BASE          = 32'h0000_3000;
  localparam int          IM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/ifu_npc.sv
// rtl/ifu_npc.sv - combinational branch / jump / jump-register target calculator
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_reg,
  output logic [31:0] target
);

  logic [31:0] seq;

  // No delay slot: every target is relative to the instruction after the redirecting one
  assign seq = redir_pc + 32'd4;

  // Select the target for the requested redirect kind; wraps at 32 bits
  always_comb begin
    target = seq;
    case (redir_op_e'(redir_op))
      REDIR_BR: target = seq + {{14{redir_imm[15]}}, redir_imm[15:0], 2'b00};
      REDIR_J:  target = {seq[31:28], redir_imm, 2'b00};
      REDIR_JR: target = redir_reg;
      default:  target = seq;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: PC, window check, output register, fault flag
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IM_BASE,
  parameter int          IM_WORDS = IM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic [1:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [25:0] redir_imm,
  input  logic [31:0] redir_reg,
  output logic        fault
);

  localparam logic [31:0] WIN_BYTES = 32'(4 * IM_WORDS);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] target;
  logic [31:0] pc_off;
  logic        addr_bad;
  logic        redirect;
  logic        accept;

  ifu_npc u_npc (
    .redir_op  (redir_op),
    .redir_pc  (redir_pc),
    .redir_imm (redir_imm),
    .redir_reg (redir_reg),
    .target    (target)
  );

  // Offset is unsigned, so a pc below the base also wraps to a huge offset
  assign pc_off   = pc_q - RESET_PC;
  assign addr_bad = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_off >= WIN_BYTES);
  assign redirect = (redir_op != REDIR_NONE);
  assign accept   = valid_q && id_ready;

  // Next state: redirect beats fault beats window error beats load beats stall
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (redirect) begin
      pc_d    = target;
      valid_d = 1'b0;
    end else if (fault_q) begin
      if (accept) valid_d = 1'b0;
    end else if (addr_bad) begin
      fault_d = 1'b1;
      if (accept) valid_d = 1'b0;
    end else if (!valid_q || id_ready) begin
      instr_d = imem_instr;
      id_pc_d = pc_q;
      valid_d = 1'b1;
      pc_d    = pc_q + 32'd4;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      id_pc_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = valid_q;
  assign id_instr  = instr_q;
  assign id_pc     = id_pc_q;
  assign fault     = fault_q;

endmodule
